reconstrutor_caminho: RTL and testbench

RECONSTRUTOR_CAMINHO -- requirements
Module: reconstrutor_caminho

---
 rtl/reconstrutor_caminho.sv | 147 ++++++++++++++
 tb/tb_reconstrutor_caminho.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reconstrutor_caminho.sv
// Path reconstructor: walks the predecessor RAM from destination back to source, streaming one node per valid/ready beat.
// Next node is presented on the third cycle after each accepted beat; no_out/ultimo_out hold stable while stalled.
module reconstrutor_caminho #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    MAX_PASSOS   = 2 ** ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SEM_ANTERIOR = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  limpar_in,
    input  logic                  write_en_in,
    input  logic [ADDR_WIDTH-1:0] write_addr_in,
    input  logic [ADDR_WIDTH-1:0] write_data_in,
    input  logic                  iniciar_in,
    input  logic [ADDR_WIDTH-1:0] top_fonte_in,
    input  logic [ADDR_WIDTH-1:0] top_destino_in,
    input  logic                  abortar_in,
    output logic [ADDR_WIDTH-1:0] no_out,
    output logic                  no_valid_out,
    input  logic                  no_ready_in,
    output logic                  ultimo_out,
    output logic [ADDR_WIDTH:0]   comprimento_out,
    output logic                  ocupado_out,
    output logic                  pronto_out,
    output logic                  erro_out
);
    localparam logic [ADDR_WIDTH:0] MAX_L = (ADDR_WIDTH + 1)'(MAX_PASSOS);

    typedef enum logic [2:0] {OCIOSO, LIMPA, EMITE, LER, ESPERA} estado_t;

    estado_t               estado_q;
    logic [ADDR_WIDTH-1:0] mem_q [2 ** ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] no_q;
    logic [ADDR_WIDTH-1:0] fonte_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] rd_dat_q;
    logic [ADDR_WIDTH-1:0] limpa_q;
    logic [ADDR_WIDTH:0]   comp_q;
    logic [ADDR_WIDTH:0]   comp_d;
    logic                  valid_q;
    logic                  ultimo_q;
    logic                  pronto_q;
    logic                  erro_q;
    logic                  hs;

    assign hs     = valid_q && no_ready_in;
    assign comp_d = comp_q + 1'b1;

    // Predecessor store: no reset, solver writes only while idle, one read per cycle.
    always_ff @(posedge clk) begin
        if (estado_q == LIMPA) begin
            mem_q[limpa_q] <= SEM_ANTERIOR;
        end else if (estado_q == OCIOSO && write_en_in) begin
            mem_q[write_addr_in] <= write_data_in;
        end
        rd_dat_q <= mem_q[rd_addr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            no_q      <= '0;
            fonte_q   <= '0;
            rd_addr_q <= '0;
            limpa_q   <= '0;
            comp_q    <= '0;
            valid_q   <= 1'b0;
            ultimo_q  <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (limpar_in) begin
                        estado_q <= LIMPA;
                        limpa_q  <= '0;
                        erro_q   <= 1'b0;
                    end else if (iniciar_in) begin
                        estado_q <= EMITE;
                        no_q     <= top_destino_in;
                        fonte_q  <= top_fonte_in;
                        ultimo_q <= (top_destino_in == top_fonte_in);
                        valid_q  <= 1'b1;
                        comp_q   <= '0;
                        erro_q   <= 1'b0;
                    end
                end
                LIMPA: begin
                    limpa_q <= limpa_q + 1'b1;
                    if (&limpa_q) begin
                        estado_q <= OCIOSO;
                    end
                end
                EMITE: begin
                    if (hs) begin
                        comp_q <= comp_d;
                    end
                    if (abortar_in || hs) begin
                        valid_q  <= 1'b0;
                        ultimo_q <= 1'b0;
                    end
                    // An abort wins over whatever the accepted beat would have triggered.
                    if (abortar_in) begin
                        estado_q <= OCIOSO;
                    end else if (hs) begin
                        if (ultimo_q) begin
                            estado_q <= OCIOSO;
                            pronto_q <= 1'b1;
                        end else if (comp_d == MAX_L) begin
                            estado_q <= OCIOSO;
                            erro_q   <= 1'b1;
                        end else begin
                            rd_addr_q <= no_q;
                            estado_q  <= LER;
                        end
                    end
                end
                LER: begin
                    estado_q <= abortar_in ? OCIOSO : ESPERA;
                end
                ESPERA: begin
                    if (abortar_in) begin
                        estado_q <= OCIOSO;
                    end else if (rd_dat_q == SEM_ANTERIOR) begin
                        estado_q <= OCIOSO;
                        erro_q   <= 1'b1;
                    end else begin
                        estado_q <= EMITE;
                        no_q     <= rd_dat_q;
                        ultimo_q <= (rd_dat_q == fonte_q);
                        valid_q  <= 1'b1;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign no_out          = no_q;
    assign no_valid_out    = valid_q;
    assign ultimo_out      = ultimo_q;
    assign comprimento_out = comp_q;
    assign ocupado_out     = (estado_q != OCIOSO);
    assign pronto_out      = pronto_q;
    assign erro_out        = erro_q;
endmodule

// File: tb/tb_reconstrutor_caminho.sv
// Bench for reconstrutor_caminho: directed scenarios plus randomized walks scored against a path model.
module tb_reconstrutor_caminho;
    localparam int AW = 4;
    localparam int MAXP = 16;
    localparam logic [AW-1:0] SEM = 4'd15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          limpar_in = 1'b0;
    logic          write_en_in = 1'b0;
    logic [AW-1:0] write_addr_in = '0;
    logic [AW-1:0] write_data_in = '0;
    logic          iniciar_in = 1'b0;
    logic [AW-1:0] top_fonte_in = '0;
    logic [AW-1:0] top_destino_in = '0;
    logic          abortar_in = 1'b0;
    logic [AW-1:0] no_out;
    logic          no_valid_out;
    logic          no_ready_in = 1'b0;
    logic          ultimo_out;
    logic [AW:0]   comprimento_out;
    logic          ocupado_out;
    logic          pronto_out;
    logic          erro_out;

    reconstrutor_caminho #(.ADDR_WIDTH(AW), .MAX_PASSOS(MAXP), .SEM_ANTERIOR(SEM)) dut (
        .clk(clk), .rst(rst), .limpar_in(limpar_in), .write_en_in(write_en_in),
        .write_addr_in(write_addr_in), .write_data_in(write_data_in), .iniciar_in(iniciar_in),
        .top_fonte_in(top_fonte_in), .top_destino_in(top_destino_in), .abortar_in(abortar_in),
        .no_out(no_out), .no_valid_out(no_valid_out), .no_ready_in(no_ready_in),
        .ultimo_out(ultimo_out), .comprimento_out(comprimento_out), .ocupado_out(ocupado_out),
        .pronto_out(pronto_out), .erro_out(erro_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [AW-1:0] ref_mem [16];
    logic [AW-1:0] exp_beats [$];
    bit            exp_err;

    logic [AW-1:0] got_beats [$];
    logic          got_ult [$];
    int            got_pronto;
    int            stall_err;
    int            stalled;
    bit            timeout;
    logic          got_erro;
    logic [AW:0]   got_len;

    // Reference: follow predecessor links from the destination until source, dead end or step limit.
    task automatic model_walk(input logic [AW-1:0] f, input logic [AW-1:0] d);
        logic [AW-1:0] n;
        n = d;
        exp_beats.delete();
        exp_err = 1'b0;
        while (1) begin
            exp_beats.push_back(n);
            if (n == f) break;
            if (exp_beats.size() == MAXP) begin exp_err = 1'b1; break; end
            if (ref_mem[n] == SEM) begin exp_err = 1'b1; break; end
            n = ref_mem[n];
        end
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [AW-1:0] v);
        @(negedge clk);
        write_en_in = 1'b1; write_addr_in = a; write_data_in = v;
        @(negedge clk);
        write_en_in = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic do_limpar();
        @(negedge clk);
        limpar_in = 1'b1;
        @(negedge clk);
        limpar_in = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 16; i++) ref_mem[i] = SEM;
    endtask

    // Drives one walk, collecting accepted beats; stall_idx selects a beat held off for four cycles.
    task automatic run_walk(input logic [AW-1:0] f, input logic [AW-1:0] d,
                            input int ready_pct, input int stall_idx);
        bit prev_stall;
        logic [AW-1:0] prev_no;
        logic prev_ult;
        got_beats.delete(); got_ult.delete();
        got_pronto = 0; stall_err = 0; stalled = 0; timeout = 1'b1;
        prev_stall = 1'b0; prev_no = '0; prev_ult = 1'b0;
        @(negedge clk);
        top_fonte_in = f; top_destino_in = d; iniciar_in = 1'b1;
        @(negedge clk);
        iniciar_in = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            if (no_valid_out && got_beats.size() == stall_idx && stalled < 4) begin
                no_ready_in = 1'b0;
                stalled++;
            end else begin
                no_ready_in = ($urandom_range(99) < ready_pct);
            end
            if (prev_stall && (!no_valid_out || no_out !== prev_no || ultimo_out !== prev_ult))
                stall_err++;
            if (pronto_out) got_pronto++;
            if (no_valid_out && no_ready_in) begin
                got_beats.push_back(no_out);
                got_ult.push_back(ultimo_out);
            end
            prev_stall = no_valid_out && !no_ready_in;
            prev_no = no_out;
            prev_ult = ultimo_out;
            if (!ocupado_out) begin timeout = 1'b0; break; end
        end
        got_erro = erro_out;
        got_len = comprimento_out;
        no_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({no_out, no_valid_out, ultimo_out, comprimento_out, ocupado_out, pronto_out, erro_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got no=%0d v=%b u=%b len=%0d busy=%b ok=%b err=%b, need all 0",
                     no_out, no_valid_out, ultimo_out, comprimento_out, ocupado_out, pronto_out, erro_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ocupado_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: ocupado=%b need 0", ocupado_out);
        end
    endtask

    task automatic test_limpar();
        int busy_low;
        busy_low = 0;
        @(negedge clk);
        limpar_in = 1'b1;
        @(negedge clk);
        limpar_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ocupado_out !== 1'b1) busy_low++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_low != 0) begin
            n_fail++; $display("FAIL limpar_busy: %0d idle cycles seen during clear, need 0", busy_low);
        end
        n_checks++;
        if (ocupado_out !== 1'b0) begin
            n_fail++; $display("FAIL limpar_len: ocupado=%b after 16 cycles, need 0", ocupado_out);
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = SEM;
    endtask

    task automatic test_path_basic();
        logic [AW-1:0] want [3];
        want = '{4'd5, 4'd3, 4'd1};
        ram_write(4'd5, 4'd3);
        ram_write(4'd3, 4'd1);
        run_walk(4'd1, 4'd5, 100, -1);
        n_checks++;
        if (timeout || got_beats.size() != 3) begin
            n_fail++; $display("FAIL basic_count: beats=%0d timeout=%b, need 3", got_beats.size(), timeout);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_beats[i] !== want[i] || got_ult[i] !== (i == 2)) begin
                    n_fail++; $display("FAIL basic_beat%0d: no=%0d ult=%b, need no=%0d ult=%b",
                                       i, got_beats[i], got_ult[i], want[i], (i == 2));
                end
            end
        end
        n_checks++;
        if (got_pronto != 1 || got_erro !== 1'b0 || got_len !== 5'd3) begin
            n_fail++; $display("FAIL basic_done: pronto=%0d erro=%b len=%0d, need 1 0 3", got_pronto, got_erro, got_len);
        end
    endtask

    task automatic test_backpressure();
        run_walk(4'd1, 4'd5, 100, 1);
        n_checks++;
        if (stalled != 4 || stall_err != 0) begin
            n_fail++; $display("FAIL bp_stable: stalled=%0d unstable=%0d, need 4 0", stalled, stall_err);
        end
        n_checks++;
        if (timeout || got_beats.size() != 3 || got_beats[0] !== 4'd5 || got_beats[1] !== 4'd3 || got_beats[2] !== 4'd1) begin
            n_fail++; $display("FAIL bp_beats: count=%0d timeout=%b, need 5,3,1", got_beats.size(), timeout);
        end
        n_checks++;
        if (got_pronto != 1 || got_len !== 5'd3) begin
            n_fail++; $display("FAIL bp_done: pronto=%0d len=%0d, need 1 3", got_pronto, got_len);
        end
    endtask

    task automatic test_single();
        run_walk(4'd4, 4'd4, 100, -1);
        n_checks++;
        if (timeout || got_beats.size() != 1 || got_beats[0] !== 4'd4 || got_ult[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_beat: count=%0d timeout=%b, need one beat 4 with ultimo", got_beats.size(), timeout);
        end
        n_checks++;
        if (got_pronto != 1 || got_erro !== 1'b0 || got_len !== 5'd1) begin
            n_fail++; $display("FAIL single_done: pronto=%0d erro=%b len=%0d, need 1 0 1", got_pronto, got_erro, got_len);
        end
    endtask

    task automatic test_loop_guard();
        int bad;
        bad = 0;
        ram_write(4'd2, 4'd7);
        ram_write(4'd7, 4'd2);
        run_walk(4'd0, 4'd2, 80, -1);
        for (int i = 0; i < got_beats.size(); i++)
            if (got_beats[i] !== ((i % 2 == 0) ? 4'd2 : 4'd7) || got_ult[i] !== 1'b0) bad++;
        n_checks++;
        if (timeout || got_beats.size() != 16 || bad != 0) begin
            n_fail++; $display("FAIL loop_beats: count=%0d wrong=%0d timeout=%b, need 16 alternating 2,7",
                               got_beats.size(), bad, timeout);
        end
        n_checks++;
        if (got_erro !== 1'b1 || got_pronto != 0 || got_len !== 5'd16) begin
            n_fail++; $display("FAIL loop_err: erro=%b pronto=%0d len=%0d, need 1 0 16", got_erro, got_pronto, got_len);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (erro_out !== 1'b1) begin
            n_fail++; $display("FAIL loop_sticky: erro=%b need 1", erro_out);
        end
    endtask

    task automatic test_sem_anterior();
        do_limpar();
        n_checks++;
        if (erro_out !== 1'b0) begin
            n_fail++; $display("FAIL limpar_clears_err: erro=%b need 0", erro_out);
        end
        run_walk(4'd0, 4'd9, 100, -1);
        n_checks++;
        if (timeout || got_beats.size() != 1 || got_beats[0] !== 4'd9) begin
            n_fail++; $display("FAIL sem_beat: count=%0d timeout=%b, need one beat 9", got_beats.size(), timeout);
        end
        n_checks++;
        if (got_erro !== 1'b1 || got_pronto != 0 || got_len !== 5'd1) begin
            n_fail++; $display("FAIL sem_err: erro=%b pronto=%0d len=%0d, need 1 0 1", got_erro, got_pronto, got_len);
        end
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        ram_write(4'd5, 4'd3);
        ram_write(4'd3, 4'd1);
        @(negedge clk);
        top_fonte_in = 4'd1; top_destino_in = 4'd5; no_ready_in = 1'b1; iniciar_in = 1'b1;
        @(negedge clk);
        iniciar_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ocupado_out !== 1'b1 || no_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre: ocupado=%b valid=%b, need 1 0", ocupado_out, no_valid_out);
        end
        abortar_in = 1'b1;
        write_en_in = 1'b1; write_addr_in = 4'd5; write_data_in = 4'd9;
        @(negedge clk);
        abortar_in = 1'b0; write_en_in = 1'b0; no_ready_in = 1'b0;
        n_checks++;
        if (ocupado_out !== 1'b0 || no_valid_out !== 1'b0 || erro_out !== 1'b0 || comprimento_out !== 5'd1) begin
            n_fail++; $display("FAIL abort_idle: ocupado=%b valid=%b erro=%b len=%0d, need 0 0 0 1",
                               ocupado_out, no_valid_out, erro_out, comprimento_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (pronto_out || ocupado_out) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL abort_quiet: %0d busy/pronto cycles after abort, need 0", pulses);
        end
        model_walk(4'd1, 4'd5);
        run_walk(4'd1, 4'd5, 100, -1);
        n_checks++;
        if (timeout || got_beats.size() != exp_beats.size() || got_beats[0] !== 4'd5 || got_beats[1] !== 4'd3) begin
            n_fail++; $display("FAIL abort_ram: count=%0d first=%0d, need 3 beats 5,3,1 (write ignored)",
                               got_beats.size(), got_beats.size() > 0 ? got_beats[0] : 4'd0);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] f;
        logic [AW-1:0] d;
        int bad;
        for (int it = 0; it < 24; it++) begin
            if (it == 12) do_limpar();
            for (int w = 0; w < 3; w++)
                ram_write(AW'($urandom_range(15)), AW'($urandom_range(15)));
            f = AW'($urandom_range(15));
            d = (it % 5 == 0) ? f : AW'($urandom_range(15));
            model_walk(f, d);
            run_walk(f, d, $urandom_range(100, 40), -1);
            bad = 0;
            if (got_beats.size() == exp_beats.size()) begin
                for (int i = 0; i < exp_beats.size(); i++)
                    if (got_beats[i] !== exp_beats[i] || got_ult[i] !== (exp_beats[i] == f)) bad++;
            end
            n_checks++;
            if (timeout || got_beats.size() != exp_beats.size() || bad != 0) begin
                n_fail++; $display("FAIL rand%0d_path: f=%0d d=%0d beats=%0d wrong=%0d timeout=%b, need %0d beats",
                                   it, f, d, got_beats.size(), bad, timeout, exp_beats.size());
            end
            n_checks++;
            if (got_erro !== exp_err || got_pronto != (exp_err ? 0 : 1) || got_len !== (AW+1)'(exp_beats.size())
                || stall_err != 0) begin
                n_fail++; $display("FAIL rand%0d_end: erro=%b pronto=%0d len=%0d unstable=%0d, need %b %0d %0d 0",
                                   it, got_erro, got_pronto, got_len, stall_err, exp_err, exp_err ? 0 : 1, exp_beats.size());
            end
        end
    endtask

    task automatic test_rst_in_limpar();
        @(negedge clk);
        limpar_in = 1'b1;
        @(negedge clk);
        limpar_in = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (ocupado_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_limpa_pre: ocupado=%b need 1", ocupado_out);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({no_out, no_valid_out, ultimo_out, comprimento_out, ocupado_out, pronto_out, erro_out} !== '0) begin
            n_fail++; $display("FAIL rst_limpa: got no=%0d v=%b u=%b len=%0d busy=%b ok=%b err=%b, need all 0",
                               no_out, no_valid_out, ultimo_out, comprimento_out, ocupado_out, pronto_out, erro_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ocupado_out !== 1'b0 || pronto_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_limpa_after: ocupado=%b pronto=%b need 0 0", ocupado_out, pronto_out);
        end
    endtask

    initial begin
        test_reset();
        test_limpar();
        test_path_basic();
        test_backpressure();
        test_single();
        test_loop_guard();
        test_sem_anterior();
        test_abort();
        test_random();
        test_rst_in_limpar();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
